// File: rtl/key_mode_ctrl_pkg.sv
// Shared encodings and helpers for the key/mode control sequencer.
// Cycle counts are derived from millisecond figures at elaboration time.
package key_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } set_state_e;

   typedef enum logic {
      DM_CLOCK = 1'b0,
      DM_SW    = 1'b1
   } disp_mode_e;

   localparam int unsigned HOLD_W = 32;

   function automatic int unsigned ms_to_cyc(input int unsigned clk_freq, input int unsigned ms);
      return clk_freq / 1000 * ms;
   endfunction

   // SET_SEC wraps back to NORMAL through the natural 2-bit rollover
   function automatic set_state_e next_field(input set_state_e st);
      return set_state_e'(st + 2'd1);
   endfunction

endpackage

// File: rtl/key_mode_ctrl_edge.sv
// Press detector: previous-level register plus rising-level detect.
// Previous level resets high so a key held through reset is not a press.
module key_edge (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic press_o
);

   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= 1'b1;
      else       prev_q <= level_i;
   end

   assign press_o = level_i & ~prev_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Key sequencer: press events -> display/set-mode FSM, field increment
// pulses with long-press auto-repeat, and stopwatch run/clear control.
module key_mode_ctrl
   import key_mode_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned LONG_MS   = 1000,
   parameter int unsigned REPEAT_MS = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_inc,
   output logic       disp_mode,
   output logic [1:0] set_state,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       inc_sec,
   output logic       sw_run,
   output logic       sw_clear
);

   localparam int unsigned LONG_CYC   = ms_to_cyc(CLK_FREQ, LONG_MS);
   localparam int unsigned REPEAT_CYC = ms_to_cyc(CLK_FREQ, REPEAT_MS);

   logic mode_press, sel_press, inc_press;

   key_edge u_edge_mode (.clk(clk), .reset(reset), .level_i(key_mode), .press_o(mode_press));
   key_edge u_edge_sel  (.clk(clk), .reset(reset), .level_i(key_sel),  .press_o(sel_press));
   key_edge u_edge_inc  (.clk(clk), .reset(reset), .level_i(key_inc),  .press_o(inc_press));

   set_state_e              state_q;
   disp_mode_e              disp_q;
   logic                    sw_run_q, sw_clear_q;
   logic                    inc_hour_q, inc_min_q, inc_sec_q;
   logic                    armed_q;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [HOLD_W-1:0]       rep_q, rep_d;
   logic                    fire;

   assign hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
   assign rep_d  = rep_q + 1'b1;

   // One increment pulse at most per cycle; higher-priority presses swallow it
   always_comb begin
      fire = 1'b0;
      if (!mode_press && !sel_press) begin
         if (inc_press)
            fire = (disp_q == DM_CLOCK) && (state_q != ST_NORMAL);
         else if (armed_q && key_inc)
            fire = (hold_q < LONG_CYC) ? (hold_d == LONG_CYC) : (rep_d == REPEAT_CYC);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_NORMAL;
         disp_q     <= DM_CLOCK;
         sw_run_q   <= 1'b0;
         sw_clear_q <= 1'b0;
         inc_hour_q <= 1'b0;
         inc_min_q  <= 1'b0;
         inc_sec_q  <= 1'b0;
         armed_q    <= 1'b0;
         hold_q     <= '0;
         rep_q      <= '0;
      end else begin
         inc_hour_q <= fire && (state_q == ST_SET_HOUR);
         inc_min_q  <= fire && (state_q == ST_SET_MIN);
         inc_sec_q  <= fire && (state_q == ST_SET_SEC);
         sw_clear_q <= 1'b0;
         if (mode_press) begin
            armed_q <= 1'b0;
            hold_q  <= '0;
            rep_q   <= '0;
            if (state_q == ST_NORMAL)
               disp_q <= (disp_q == DM_CLOCK) ? DM_SW : DM_CLOCK;
            else
               state_q <= ST_NORMAL;
         end else if (sel_press) begin
            armed_q <= 1'b0;
            hold_q  <= '0;
            rep_q   <= '0;
            if (disp_q == DM_CLOCK)
               state_q <= next_field(state_q);
            else
               sw_run_q <= ~sw_run_q;
         end else if (inc_press) begin
            if (disp_q == DM_SW && !sw_run_q)
               sw_clear_q <= 1'b1;
            if (fire) begin
               armed_q <= 1'b1;
               hold_q  <= '0;
               rep_q   <= '0;
            end
         end else if (armed_q && key_inc) begin
            // rep_q only runs once the long-press threshold has been crossed
            hold_q <= hold_d;
            if (hold_q < LONG_CYC || rep_d == REPEAT_CYC)
               rep_q <= '0;
            else
               rep_q <= rep_d;
         end else begin
            armed_q <= 1'b0;
            hold_q  <= '0;
            rep_q   <= '0;
         end
      end
   end

   assign disp_mode = disp_q;
   assign set_state = state_q;
   assign inc_hour  = inc_hour_q;
   assign inc_min   = inc_min_q;
   assign inc_sec   = inc_sec_q;
   assign sw_run    = sw_run_q;
   assign sw_clear  = sw_clear_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl: directed scenarios plus random key activity,
// checked every cycle against a behavioural model of the key rules.
module tb_key_mode_ctrl;

   localparam int CF = 1000;
   localparam int LM = 10;
   localparam int RM = 4;
   localparam int LONG = CF / 1000 * LM;
   localparam int REP  = CF / 1000 * RM;

   logic clk = 1'b0;
   logic reset, key_mode, key_sel, key_inc;
   logic disp_mode, inc_hour, inc_min, inc_sec, sw_run, sw_clear;
   logic [1:0] set_state;

   always #5 clk = ~clk;

   key_mode_ctrl #(.CLK_FREQ(CF), .LONG_MS(LM), .REPEAT_MS(RM)) dut (
      .clk(clk), .reset(reset),
      .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
      .disp_mode(disp_mode), .set_state(set_state),
      .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
      .sw_run(sw_run), .sw_clear(sw_clear)
   );

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state
   logic [2:0] m_prev;
   logic       m_disp, m_run, m_clr, m_ih, m_im, m_is;
   int         m_state;
   bit         m_holding;
   int         m_elapsed;

   function automatic void model_reset();
      m_prev = 3'b111;
      m_disp = 0; m_run = 0; m_clr = 0; m_ih = 0; m_im = 0; m_is = 0;
      m_state = 0; m_holding = 0; m_elapsed = 0;
   endfunction

   function automatic void model_pulse(input int field);
      if (field == 1) m_ih = 1;
      if (field == 2) m_im = 1;
      if (field == 3) m_is = 1;
   endfunction

   function automatic void model_step();
      bit pm, ps, pi;
      pm = key_mode && !m_prev[2];
      ps = key_sel  && !m_prev[1];
      pi = key_inc  && !m_prev[0];
      m_clr = 0; m_ih = 0; m_im = 0; m_is = 0;
      if (pm) begin
         m_holding = 0;
         if (m_state == 0) m_disp = !m_disp;
         else              m_state = 0;
      end else if (ps) begin
         m_holding = 0;
         if (!m_disp) m_state = (m_state + 1) % 4;
         else         m_run = !m_run;
      end else if (pi) begin
         if (m_disp) begin
            if (!m_run) m_clr = 1;
         end else if (m_state != 0) begin
            model_pulse(m_state);
            m_holding = 1;
            m_elapsed = 0;
         end
      end else if (m_holding && key_inc) begin
         m_elapsed++;
         if (m_elapsed == LONG || (m_elapsed > LONG && (m_elapsed - LONG) % REP == 0))
            model_pulse(m_state);
      end else begin
         m_holding = 0;
      end
      m_prev = {key_mode, key_sel, key_inc};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check(tag, {23'd0, disp_mode, set_state, inc_hour, inc_min, inc_sec, sw_run, sw_clear},
                 {23'd0, m_disp, m_state[1:0], m_ih, m_im, m_is, m_run, m_clr});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outs("cycle");
   endtask

   // which: 0 = mode, 1 = sel, 2 = inc
   task automatic press(input int which);
      if (which == 0) key_mode = 1;
      if (which == 1) key_sel  = 1;
      if (which == 2) key_inc  = 1;
      tick();
      key_mode = 0; key_sel = 0; key_inc = 0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      model_reset();
      check_outs("async_reset");
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   int offs[$];
   int exp_offs[6] = '{0, 10, 14, 18, 22, 26};
   int n_hour, n_min;

   initial begin
      key_mode = 0; key_sel = 1; key_inc = 0; reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset_state");
      reset = 0;

      // 1: sel held through reset gives no press
      repeat (3) tick();
      check("sel_held_state", {30'd0, set_state}, 32'd0);
      key_sel = 0; tick();
      key_sel = 1; tick();
      check("sel_repress_state", {30'd0, set_state}, 32'd1);
      key_sel = 0; tick();
      press(1); press(1); press(1);
      check("back_to_normal", {30'd0, set_state}, 32'd0);

      // 2: field stepping, then mode from SET_MIN
      for (int i = 1; i <= 4; i++) begin
         key_sel = 1; tick();
         check("sel_step", {30'd0, set_state}, 32'(i % 4));
         key_sel = 0; tick();
      end
      press(1); press(1);
      press(0);
      check("mode_from_set", {30'd0, set_state, disp_mode}, 32'd0);

      // 3: long-press auto-repeat in SET_MIN
      press(1); press(1);
      key_inc = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (inc_min) offs.push_back(i);
      end
      key_inc = 0;
      for (int i = 30; i < 40; i++) begin
         tick();
         if (inc_min) offs.push_back(i);
      end
      check("repeat_count", offs.size(), 6);
      for (int i = 0; i < 6 && i < offs.size(); i++)
         check("repeat_offset", offs[i], exp_offs[i]);
      press(0);

      // 4: stopwatch run/clear
      press(0);
      check("sw_view", {31'd0, disp_mode}, 32'd1);
      press(1);
      check("sw_run_on", {31'd0, sw_run}, 32'd1);
      key_inc = 1; tick();
      check("no_clear_running", {31'd0, sw_clear}, 32'd0);
      key_inc = 0; tick();
      press(1);
      check("sw_run_off", {31'd0, sw_run}, 32'd0);
      key_inc = 1; tick();
      check("clear_pulse", {31'd0, sw_clear}, 32'd1);
      key_inc = 0; tick();
      check("clear_one_cycle", {31'd0, sw_clear}, 32'd0);

      // 5: mode and sel together in clock view
      press(0);
      key_mode = 1; key_sel = 1; tick();
      check("mode_beats_sel", {29'd0, disp_mode, set_state, sw_run}, {29'd0, 1'b1, 2'd0, 1'b0});
      key_mode = 0; key_sel = 0; tick();
      press(0);

      // 6: field change mid-hold inhibits repeat
      press(1);
      n_hour = 0; n_min = 0;
      key_inc = 1;
      for (int i = 0; i < 12; i++) begin
         if (i == 5) key_sel = 1;
         if (i == 6) key_sel = 0;
         tick();
         n_hour += int'(inc_hour);
         n_min  += int'(inc_min);
      end
      check("hold_hour_pulses", n_hour, 1);
      check("hold_min_pulses", n_min, 0);
      check("hold_new_field", {30'd0, set_state}, 32'd2);
      key_inc = 0; tick();
      key_inc = 1; tick();
      check("repress_min", {31'd0, inc_min}, 32'd1);
      key_inc = 0; tick();

      // Reset in the middle of a hold
      press(1);
      key_inc = 1;
      repeat (5) tick();
      do_reset();
      repeat (3) tick();
      check("held_inc_after_reset", {29'd0, inc_hour, inc_min, inc_sec}, 32'd0);
      key_inc = 0; tick();

      // Random key activity with long holds
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) key_mode = ~key_mode;
         if ($urandom_range(0, 9) == 0)  key_sel  = ~key_sel;
         if ($urandom_range(0, 24) == 0) key_inc  = ~key_inc;
         if ($urandom_range(0, 599) == 0) do_reset();
         else tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
